// File: rtl/cycbpuf_pkg.sv
// Shared types and default constants for the cyclic bistable-ring PUF
// challenge-response sequencer.
`timescale 1ns/1ps
package cycbpuf_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Default geometry of the PUF array and the sampling schedule
    localparam int CHAL_W_DEF        = 51;
    localparam int SETTLE_CYCLES_DEF = 64;
    localparam int NUM_SAMPLES_DEF   = 15;

    // A vote is stable when every sample agreed
    function automatic logic all_agree(input int tally, input int num);
        return (tally == 0) || (tally == num);
    endfunction

endpackage

// File: rtl/cycbpuf_crp_ctrl_if.sv
// Host-side handshake bundle: challenge channel in, voted response channel out.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both high. The source holds valid and its payload
// stable until that edge; ready may change freely and never depends on a
// same-cycle combinational path from valid.
`timescale 1ns/1ps
interface cycbpuf_crp_ctrl_if #(
    parameter int CHAL_W = 51
);
    logic              chal_valid;
    logic              chal_ready;
    logic [CHAL_W-1:0] chal;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp;
    logic              resp_stable;

    // Host / CRP-collection side
    modport master (
        output chal_valid, chal, resp_ready,
        input  chal_ready, resp_valid, resp, resp_stable
    );

    // Sequencer side
    modport slave (
        input  chal_valid, chal, resp_ready,
        output chal_ready, resp_valid, resp, resp_stable
    );
endinterface

// File: rtl/cycbpuf_resp_sync.sv
// Two-flop synchronizer that brings the free-running PUF response into clk.
`timescale 1ns/1ps
module cycbpuf_resp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);
    logic meta;
    logic stable;

    // First flop may go metastable; the second gives it a cycle to resolve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            stable <= 1'b0;
        end else begin
            meta   <= async_in;
            stable <= meta;
        end
    end

    assign sync_out = stable;
endmodule

// File: rtl/cycbpuf_crp_ctrl.sv
// Challenge-response sequencer: latches a challenge onto the PUF, waits for
// the ring to settle, majority-votes NUM_SAMPLES synchronized response
// samples and hands back the voted bit plus an all-samples-agreed flag.
`timescale 1ns/1ps
module cycbpuf_crp_ctrl
    import cycbpuf_pkg::*;
#(
    parameter int CHAL_W        = CHAL_W_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int NUM_SAMPLES   = NUM_SAMPLES_DEF,
    parameter int CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    cycbpuf_crp_ctrl_if.slave   host,
    output logic [CHAL_W-1:0]   puf_chal,
    input  logic                puf_resp,
    output logic                busy,
    output state_t              fsm_state
);
    localparam int ONES_W   = $clog2(NUM_SAMPLES + 1);
    localparam int CNT_NEED = (SETTLE_CYCLES > NUM_SAMPLES) ? SETTLE_CYCLES : NUM_SAMPLES;

    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [ONES_W-1:0] HALF        = ONES_W'(NUM_SAMPLES / 2);

    // Reject configurations the vote or the counter cannot handle
    if (NUM_SAMPLES < 1 || (NUM_SAMPLES % 2) == 0) begin : g_bad_samples
        $error("NUM_SAMPLES must be odd and >= 1");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be >= 1");
    end
    if (CNT_W < $clog2(CNT_NEED + 1)) begin : g_bad_cnt
        $error("CNT_W too narrow for SETTLE_CYCLES/NUM_SAMPLES");
    end

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [ONES_W-1:0]   ones, ones_n;
    logic [ONES_W-1:0]   tally;
    logic [CHAL_W-1:0]   chal_q, chal_n;
    logic                resp_q, resp_n;
    logic                stable_q, stable_n;
    logic                rvalid_q, rvalid_n;
    logic                sample;

    cycbpuf_resp_sync u_resp_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (puf_resp),
        .sync_out (sample)
    );

    // Running count including the sample taken this cycle
    assign tally = ones + ONES_W'(sample);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ones     <= '0;
            chal_q   <= '0;
            resp_q   <= 1'b0;
            stable_q <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            ones     <= ones_n;
            chal_q   <= chal_n;
            resp_q   <= resp_n;
            stable_q <= stable_n;
            rvalid_q <= rvalid_n;
        end
    end

    // Next-state and datapath update for the settle/sample/vote sequence
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        ones_n   = ones;
        chal_n   = chal_q;
        resp_n   = resp_q;
        stable_n = stable_q;
        rvalid_n = rvalid_q;
        case (state)
            IDLE: begin
                if (host.chal_valid) begin
                    chal_n  = host.chal;
                    cnt_n   = '0;
                    ones_n  = '0;
                    state_n = APPLY;
                end
            end
            APPLY: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_n   = '0;
                    state_n = SAMPLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            SAMPLE: begin
                ones_n = tally;
                if (cnt == SAMPLE_LAST) begin
                    resp_n   = (tally > HALF);
                    stable_n = all_agree(int'(tally), NUM_SAMPLES);
                    rvalid_n = 1'b1;
                    cnt_n    = '0;
                    state_n  = DONE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                if (host.resp_ready) begin
                    rvalid_n = 1'b0;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign host.chal_ready  = (state == IDLE);
    assign host.resp_valid  = rvalid_q;
    assign host.resp        = resp_q;
    assign host.resp_stable = stable_q;
    assign puf_chal         = chal_q;
    assign busy             = (state != IDLE);
    assign fsm_state        = state;
endmodule

// File: tb/tb_cycbpuf_crp_ctrl.sv
// Directed bench for the PUF challenge-response sequencer.
`timescale 1ns/1ps
module tb_cycbpuf_crp_ctrl;
    import cycbpuf_pkg::*;

    localparam int CW = 51;
    localparam int S  = 64;
    localparam int N  = 15;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          puf_resp = 1'b0;
    logic [CW-1:0] puf_chal;
    logic          busy;
    state_t        fsm_state;

    always #5 clk = ~clk;

    cycbpuf_crp_ctrl_if #(.CHAL_W(CW)) bus ();

    cycbpuf_crp_ctrl #(
        .CHAL_W(CW), .SETTLE_CYCLES(S), .NUM_SAMPLES(N), .CNT_W(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host      (bus),
        .puf_chal  (puf_chal),
        .puf_resp  (puf_resp),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [CW-1:0] chal;
        logic [N-1:0]  pat;      // bit k-1 = synchronized sample k
        logic          fill;     // puf_resp outside the sampling window
        logic          exp_resp;
        logic          exp_stable;
    } vec_t;

    vec_t vecs[7];

    // puf_resp value to present at edge E0+j so that it lands as sample j-(S-2)
    function automatic logic resp_for_edge(input int j, input logic [N-1:0] pat, input logic fill);
        int idx;
        idx = j - (S - 2);
        if (idx >= 1 && idx <= N) return pat[idx-1];
        return fill;
    endfunction

    // ---------------- driver ----------------
    // Called just after a clock edge with the DUT idle.
    task automatic run_crp(input string name, input logic [CW-1:0] c, input logic [N-1:0] pat,
                           input logic fill, input logic er, input logic es, input bit handshake);
        check({name, " ready_before"}, 64'(bus.chal_ready), 64'd1);
        bus.chal       = c;
        bus.chal_valid = 1'b1;
        puf_resp       = resp_for_edge(0, pat, fill);
        @(posedge clk); #1;                       // accept edge E0
        bus.chal_valid = 1'b0;
        check({name, " puf_chal"},   64'(puf_chal), 64'(c));
        check({name, " apply"},      64'(fsm_state), 64'(APPLY));
        check({name, " ready_busy"}, 64'(bus.chal_ready), 64'd0);
        for (int j = 1; j <= S + N; j++) begin
            puf_resp = resp_for_edge(j, pat, fill);
            @(posedge clk); #1;
            if (j == S + N - 1) check({name, " early_valid"}, 64'(bus.resp_valid), 64'd0);
        end
        check({name, " valid_lat"}, 64'(bus.resp_valid), 64'd1);
        check({name, " resp"},      64'(bus.resp), 64'(er));
        check({name, " stable"},    64'(bus.resp_stable), 64'(es));
        if (handshake) begin
            bus.resp_ready = 1'b1;
            @(posedge clk); #1;
            bus.resp_ready = 1'b0;
            check({name, " valid_drop"}, 64'(bus.resp_valid), 64'd0);
            check({name, " ready_back"}, 64'(bus.chal_ready), 64'd1);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        int acc_t[3];
        logic [CW-1:0] acc_c[3];
        logic [CW-1:0] next_c;
        int na;
        int bad;
        logic prev_busy;
        logic held_resp;

        vecs[0] = '{chal: 51'h1,              pat: 15'h7FFF, fill: 1'b1, exp_resp: 1'b1, exp_stable: 1'b1};
        vecs[1] = '{chal: 51'h7_FFFF_FFFF_FFFF, pat: 15'h0000, fill: 1'b0, exp_resp: 1'b0, exp_stable: 1'b1};
        vecs[2] = '{chal: 51'h2_AAAA_5555_0F0F, pat: 15'h00FF, fill: 1'b0, exp_resp: 1'b1, exp_stable: 1'b0};
        vecs[3] = '{chal: 51'h1234_5678,      pat: 15'h007F, fill: 1'b1, exp_resp: 1'b0, exp_stable: 1'b0};
        vecs[4] = '{chal: 51'h4_0000_0000_0000, pat: 15'h5555, fill: 1'b0, exp_resp: 1'b1, exp_stable: 1'b0};
        vecs[5] = '{chal: 51'h0_DEAD_BEEF_CAFE, pat: 15'h2AAA, fill: 1'b1, exp_resp: 1'b0, exp_stable: 1'b0};
        vecs[6] = '{chal: 51'h3_0303_0303_0303, pat: 15'h7FFE, fill: 1'b0, exp_resp: 1'b1, exp_stable: 1'b0};

        bus.chal_valid = 1'b0;
        bus.chal       = '0;
        bus.resp_ready = 1'b0;

        // Reset state, observed while reset is held
        #12;
        check("rst puf_chal", 64'(puf_chal), 64'd0);
        check("rst valid",    64'(bus.resp_valid), 64'd0);
        check("rst resp",     64'(bus.resp), 64'd0);
        check("rst stable",   64'(bus.resp_stable), 64'd0);
        check("rst busy",     64'(busy), 64'd0);
        check("rst state",    64'(fsm_state), 64'(IDLE));
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst ready", 64'(bus.chal_ready), 64'd1);

        // Table-driven vote patterns
        for (int v = 0; v < 7; v++) begin
            run_crp($sformatf("vec%0d", v), vecs[v].chal, vecs[v].pat, vecs[v].fill,
                    vecs[v].exp_resp, vecs[v].exp_stable, 1'b1);
        end

        // Host stalls the response for 20 cycles; a new request must wait
        run_crp("stall", 51'h15, 15'h7FFF, 1'b1, 1'b1, 1'b1, 1'b0);
        held_resp      = bus.resp;
        bus.chal       = 51'h6_6666_6666_6666;
        bus.chal_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            puf_resp = i[0];
            @(posedge clk); #1;
            if (bus.resp_valid !== 1'b1 || bus.resp !== held_resp || bus.resp_stable !== 1'b1 ||
                bus.chal_ready !== 1'b0 || puf_chal !== 51'h15) bad++;
        end
        check("stall hold", 64'(bad), 64'd0);
        bus.chal_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        check("stall drop",  64'(bus.resp_valid), 64'd0);
        check("stall ready", 64'(bus.chal_ready), 64'd1);
        check("stall keep",  64'(puf_chal), 64'h15);

        // Back-to-back requests with both sides always willing
        puf_resp       = 1'b1;
        next_c         = 51'hA1;
        bus.chal       = next_c;
        bus.chal_valid = 1'b1;
        bus.resp_ready = 1'b1;
        na = 0; bad = 0; prev_busy = 1'b0;
        for (int cyc = 1; cyc <= 260 && na < 3; cyc++) begin
            @(posedge clk); #1;
            if (busy && !prev_busy) begin
                acc_t[na] = cyc;
                acc_c[na] = next_c;
                if (puf_chal !== next_c) bad++;
                na++;
                next_c   = next_c + 51'h101;
                bus.chal = next_c;
            end else if (na > 0 && puf_chal !== acc_c[na-1]) begin
                bad++;
            end
            prev_busy = busy;
        end
        bus.chal_valid = 1'b0;
        check("b2b accepts", 64'(na), 64'd3);
        check("b2b chal",    64'(bad), 64'd0);
        if (na == 3) begin
            check("b2b gap1", 64'(acc_t[1] - acc_t[0]), 64'(S + N + 2));
            check("b2b gap2", 64'(acc_t[2] - acc_t[1]), 64'(S + N + 2));
        end
        for (int i = 0; i < 120 && busy; i++) begin
            @(posedge clk); #1;
        end
        check("b2b drain", 64'(busy), 64'd0);
        bus.resp_ready = 1'b0;

        // Reset mid-SAMPLE with ones already counted
        bus.chal       = 51'h5_A5A5_A5A5_A5A5;
        bus.chal_valid = 1'b1;
        puf_resp       = 1'b1;
        @(posedge clk); #1;
        bus.chal_valid = 1'b0;
        repeat (70) @(posedge clk);
        #1;
        check("mid state", 64'(fsm_state), 64'(SAMPLE));
        #2 rst_n = 1'b0;
        #1;
        check("mid puf_chal", 64'(puf_chal), 64'd0);
        check("mid busy",     64'(busy), 64'd0);
        check("mid valid",    64'(bus.resp_valid), 64'd0);
        check("mid state0",   64'(fsm_state), 64'(IDLE));
        puf_resp = 1'b0;
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        run_crp("after_rst", 51'h2_0000_0000_0001, 15'h0000, 1'b0, 1'b0, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #400000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
